// File: rtl/temp_sens_pkg.sv
// Shared state encoding, SPI command opcodes and command record for the
// temperature-sensor controller.
package temp_sens_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG_START,
    ST_CFG_WAIT,
    ST_POLL_WAIT,
    ST_RD_START,
    ST_RD_WAIT,
    ST_ERROR
  } state_e;

  localparam logic [7:0] CMD_WR_CFG  = 8'h08;
  localparam logic [7:0] CMD_RD_TEMP = 8'h50;

  typedef struct packed {
    logic [1:0]  wr_bytes;
    logic [1:0]  rd_bytes;
    logic [15:0] tx_data;
  } spi_cmd_t;

  // Counter width for a count of n cycles; keeps a legal 1-bit vector for n <= 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_rise.sv
// Two-flop synchroniser for an asynchronous level plus a rising-edge detector;
// rise_o pulses for one clk cycle, two edges after the input rises.
module sync_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);

  // [0],[1] are the synchroniser stages, [2] holds the previous synchronised value.
  logic [2:0] sync_q;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour, which is what makes this a shift chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], d_i};
    end
  end

  assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/temp_sens_ctrl.sv
// Temperature-sensor controller: configures the sensor over SPI once, then
// polls the temperature register periodically, with a transfer timeout.
module temp_sens_ctrl
  import temp_sens_pkg::*;
#(
  parameter int POLL_CYCLES    = 1000000,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [7:0]  cfg_data,
  output logic        spi_start,
  output logic [1:0]  spi_wr_bytes,
  output logic [1:0]  spi_rd_bytes,
  output logic [15:0] spi_tx_data,
  input  logic [31:0] spi_rx_data,
  input  logic        spi_done,
  output logic [15:0] temp_data,
  output logic        temp_valid,
  output logic        busy,
  output logic        error
);

  localparam int PW = cnt_width(POLL_CYCLES);
  localparam int TW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [TW-1:0] tmo_q, tmo_d;
  spi_cmd_t      cmd_q, cmd_d, cmd_out;
  logic [15:0]   temp_q, temp_d;
  logic          valid_q, valid_d;
  logic          done_det;
  logic          rx_unused;

  // Only the low temperature word of the receive buffer is consumed.
  assign rx_unused = ^spi_rx_data[31:16];

  sync_rise u_done_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (spi_done),
    .rise_o (done_det)
  );

  // NOTE: every variable driven here gets a default before the case statement;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d   = state_q;
    poll_d    = poll_q;
    tmo_d     = tmo_q;
    cmd_d     = cmd_q;
    temp_d    = temp_q;
    valid_d   = 1'b0;
    cmd_out   = cmd_q;
    spi_start = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_CFG_START;
      end

      ST_CFG_START, ST_RD_START: begin
        // Command is presented in the start cycle and latched so it holds until done.
        cmd_out = (state_q == ST_CFG_START) ?
                  '{wr_bytes: 2'd2, rd_bytes: 2'd0, tx_data: {CMD_WR_CFG, cfg_data}} :
                  '{wr_bytes: 2'd1, rd_bytes: 2'd2, tx_data: {CMD_RD_TEMP, 8'h00}};
        if (enable) begin
          spi_start = 1'b1;
          cmd_d     = cmd_out;
          tmo_d     = '0;
          state_d   = (state_q == ST_CFG_START) ? ST_CFG_WAIT : ST_RD_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CFG_WAIT, ST_RD_WAIT: begin
        // A done arriving on the final timeout cycle still completes the transfer.
        if (done_det) begin
          poll_d  = '0;
          state_d = enable ? ST_POLL_WAIT : ST_IDLE;
          if (state_q == ST_RD_WAIT) begin
            temp_d  = spi_rx_data[15:0];
            valid_d = 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_ERROR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      ST_POLL_WAIT: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (poll_q == POLL_LAST) begin
          state_d = ST_RD_START;
        end else begin
          poll_d = poll_q + 1'b1;
        end
      end

      ST_ERROR: begin
        if (!enable) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      poll_q  <= '0;
      tmo_q   <= '0;
      cmd_q   <= '0;
      temp_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      poll_q  <= poll_d;
      tmo_q   <= tmo_d;
      cmd_q   <= cmd_d;
      temp_q  <= temp_d;
      valid_q <= valid_d;
    end
  end

  assign spi_wr_bytes = cmd_out.wr_bytes;
  assign spi_rd_bytes = cmd_out.rd_bytes;
  assign spi_tx_data  = cmd_out.tx_data;
  assign temp_data    = temp_q;
  assign temp_valid   = valid_q;
  assign error        = (state_q == ST_ERROR);
  assign busy         = (state_q != ST_IDLE) && (state_q != ST_ERROR);

endmodule

// File: tb/tb_temp_sens_ctrl.sv
// Self-checking bench for temp_sens_ctrl: table-driven sessions, a randomized
// polling session against a cycle-arithmetic model, and directed corner cases.
module tb_temp_sens_ctrl;

  localparam int P = 50;
  localparam int T = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  cfg_data = 8'h00;
  logic [31:0] spi_rx_data = 32'h0;
  logic        spi_done = 1'b0;
  logic        spi_start;
  logic [1:0]  spi_wr_bytes, spi_rd_bytes;
  logic [15:0] spi_tx_data, temp_data;
  logic        temp_valid, busy, error;

  always #5 clk = ~clk;

  temp_sens_ctrl #(.POLL_CYCLES(P), .TIMEOUT_CYCLES(T)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .cfg_data     (cfg_data),
    .spi_start    (spi_start),
    .spi_wr_bytes (spi_wr_bytes),
    .spi_rd_bytes (spi_rd_bytes),
    .spi_tx_data  (spi_tx_data),
    .spi_rx_data  (spi_rx_data),
    .spi_done     (spi_done),
    .temp_data    (temp_data),
    .temp_valid   (temp_valid),
    .busy         (busy),
    .error        (error)
  );

  typedef struct { int c; logic [1:0] wr; logic [1:0] rd; logic [15:0] tx; } start_t;
  typedef struct { int c; logic [15:0] data; } valid_t;
  typedef struct { int d; logic [31:0] rx; } resp_t;
  typedef struct {
    logic [7:0] cfg; int cfg_d; int rd_d; logic [31:0] rx;
    logic [15:0] exp_cfg_tx; logic [15:0] exp_temp;
  } vec_t;

  start_t start_log[$];
  valid_t valid_log[$];
  resp_t  resp_q[$];
  int cyc = 0;
  int pend_due = -100;
  logic [31:0] pend_rx = 32'h0;
  int n_checks = 0;
  int n_fail = 0;

  // SPI slave model: raises spi_done d cycles after the start it answers, holds it 2 cycles.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (cyc == pend_due) begin
      spi_done    = 1'b1;
      spi_rx_data = pend_rx;
    end else if (cyc == pend_due + 2) begin
      spi_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    resp_t r;
    if (spi_start) begin
      if (resp_q.size() > 0) r = resp_q.pop_front();
      else r = '{20, 32'h0};
      start_log.push_back('{cyc, spi_wr_bytes, spi_rd_bytes, spi_tx_data});
      if (r.d > 0) begin
        pend_due = cyc + r.d;
        pend_rx  = r.rx;
      end
    end
    if (temp_valid) valid_log.push_back('{cyc, temp_data});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic drive();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_start(input int budget, output start_t s);
    int n0 = start_log.size();
    s = '{-1, 2'd0, 2'd0, 16'h0};
    for (int i = 0; i < budget && start_log.size() == n0; i++) nxt();
    n_checks++;
    if (start_log.size() == n0) begin
      n_fail++;
      $display("FAIL wait_start: no spi_start within %0d cycles", budget);
    end else begin
      s = start_log[n0];
    end
  endtask

  task automatic wait_valid(input int budget, output valid_t v);
    int n0 = valid_log.size();
    v = '{-1, 16'h0};
    for (int i = 0; i < budget && valid_log.size() == n0; i++) nxt();
    n_checks++;
    if (valid_log.size() == n0) begin
      n_fail++;
      $display("FAIL wait_valid: no temp_valid within %0d cycles", budget);
    end else begin
      v = valid_log[n0];
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    start_t s, r;
    valid_t v;
    int rd_d[6];
    logic [31:0] rd_rx[6];
    int cfg_d, exp_c, exp_v, n0;
    logic [7:0] rcfg;

    vecs[0] = '{8'h80, 20, 20, 32'h0000_0C80, 16'h0880, 16'h0C80};
    vecs[1] = '{8'h00, 1, 37, 32'hFFFF_1234, 16'h0800, 16'h1234};
    vecs[2] = '{8'hFF, 5, 1, 32'h89AB_FFFF, 16'h08FF, 16'hFFFF};
    vecs[3] = '{8'h3C, 30, 10, 32'h5555_0000, 16'h083C, 16'h0000};

    // Reset state
    repeat (2) nxt();
    check("reset_outs", {spi_start, spi_wr_bytes, spi_rd_bytes, spi_tx_data, temp_valid, busy, error}, 0);
    check("reset_temp", temp_data, 0);
    drive(); rst_n = 1'b1;
    nxt();
    check("idle_busy", busy, 0);

    // Table-driven sessions: configure, one read, disable during the poll wait
    for (int i = 0; i < 4; i++) begin
      resp_q.push_back('{vecs[i].cfg_d, 32'h0});
      resp_q.push_back('{vecs[i].rd_d, vecs[i].rx});
      drive(); cfg_data = vecs[i].cfg; enable = 1'b1;
      wait_start(10, s);
      check("cfg_tx", s.tx, vecs[i].exp_cfg_tx);
      check("cfg_wr", s.wr, 2);
      check("cfg_rd", s.rd, 0);
      wait_start(vecs[i].cfg_d + P + 10, r);
      check("rd_gap", r.c - s.c, vecs[i].cfg_d + 3 + P);
      check("rd_tx", r.tx, 16'h5000);
      check("rd_wr", r.wr, 1);
      check("rd_rd", r.rd, 2);
      wait_valid(vecs[i].rd_d + 10, v);
      check("temp_data", v.data, vecs[i].exp_temp);
      check("valid_lat", v.c - r.c, vecs[i].rd_d + 3);
      nxt();
      check("valid_width", temp_valid, 0);
      check("temp_hold", temp_data, vecs[i].exp_temp);
      drive(); enable = 1'b0;
      nxt();
      check("session_idle", busy, 0);
    end

    // Randomized polling session against arithmetic timing model
    start_log.delete();
    valid_log.delete();
    cfg_d = $urandom_range(1, T - 3);
    resp_q.push_back('{cfg_d, 32'h0});
    for (int i = 0; i < 6; i++) begin
      rd_d[i]  = $urandom_range(1, T - 3);
      rd_rx[i] = $urandom;
      resp_q.push_back('{rd_d[i], rd_rx[i]});
    end
    rcfg = 8'($urandom);
    drive(); cfg_data = rcfg; enable = 1'b1;
    for (int k = 0; k < 7 * (P + T + 10) && valid_log.size() < 6; k++) nxt();
    drive(); enable = 1'b0;
    repeat (3) nxt();
    check("rand_starts", start_log.size(), 7);
    check("rand_valids", valid_log.size(), 6);
    if (start_log.size() == 7 && valid_log.size() == 6) begin
      check("rand_cfg_tx", start_log[0].tx, {8'h08, rcfg});
      exp_c = start_log[0].c + cfg_d + 3 + P;
      for (int i = 0; i < 6; i++) begin
        check("rand_start_cycle", start_log[i+1].c, exp_c);
        check("rand_rd_tx", start_log[i+1].tx, 16'h5000);
        exp_v = exp_c + rd_d[i] + 3;
        check("rand_valid_cycle", valid_log[i].c, exp_v);
        check("rand_temp", valid_log[i].data, rd_rx[i][15:0]);
        exp_c = exp_v + P;
      end
    end

    // Read never completes: timeout to ERROR, sticky until enable drops
    resp_q.push_back('{20, 32'h0});
    resp_q.push_back('{-1, 32'h0});
    drive(); enable = 1'b1;
    wait_start(10, s);
    wait_start(20 + P + 10, r);
    while (cyc < r.c + T) nxt();
    check("pre_tmo_err", error, 0);
    check("pre_tmo_busy", busy, 1);
    nxt();
    check("tmo_err", error, 1);
    check("tmo_busy", busy, 0);
    repeat (3) nxt();
    check("err_sticky", error, 1);
    drive(); enable = 1'b0;
    nxt();
    check("err_clear", error, 0);
    check("err_idle_busy", busy, 0);

    // Done detected on the last timeout cycle: done wins
    resp_q.push_back('{20, 32'h0});
    resp_q.push_back('{T - 2, 32'hDEAD_0ABC});
    drive(); enable = 1'b1;
    wait_start(10, s);
    wait_start(20 + P + 10, r);
    wait_valid(T + 10, v);
    check("tie_lat", v.c - r.c, T + 1);
    check("tie_data", v.data, 16'h0ABC);
    check("tie_err", error, 0);
    nxt();
    check("tie_err_after", error, 0);
    check("tie_busy", busy, 1);

    // enable low during POLL_WAIT: IDLE next cycle, no further starts
    repeat (3) nxt();
    n0 = start_log.size();
    drive(); enable = 1'b0;
    nxt();
    check("poll_abort_busy", busy, 0);
    repeat (P + 10) nxt();
    check("poll_abort_nostart", start_log.size(), n0);

    // enable low during RD_WAIT: capture completes, then IDLE
    resp_q.push_back('{5, 32'h0});
    resp_q.push_back('{15, 32'h0000_0BEE});
    drive(); enable = 1'b1;
    wait_start(10, s);
    wait_start(5 + P + 10, r);
    drive(); enable = 1'b0;
    wait_valid(30, v);
    check("rdwait_abort_data", v.data, 16'h0BEE);
    check("rdwait_abort_lat", v.c - r.c, 18);
    check("rdwait_abort_busy", busy, 0);
    n0 = start_log.size();
    repeat (P + 10) nxt();
    check("rdwait_abort_nostart", start_log.size(), n0);

    // Reset mid RD_WAIT: later spi_done is ignored
    resp_q.push_back('{5, 32'h0});
    resp_q.push_back('{20, 32'h0000_7777});
    drive(); enable = 1'b1;
    wait_start(10, s);
    wait_start(5 + P + 10, r);
    repeat (5) nxt();
    drive(); rst_n = 1'b0; enable = 1'b0;
    nxt();
    check("rst_mid_outs", {spi_start, spi_wr_bytes, spi_rd_bytes, spi_tx_data, temp_valid, busy, error}, 0);
    check("rst_mid_temp", temp_data, 0);
    drive(); rst_n = 1'b1;
    n0 = valid_log.size();
    repeat (30) nxt();
    check("rst_no_valid", valid_log.size(), n0);
    check("rst_temp_after", temp_data, 0);
    check("rst_busy_after", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/temp_sens_ctrl.md
TEMP_SENS_CTRL -- requirements
Module: temp_sens_ctrl

Interface
REQ-001 Parameter POLL_CYCLES, default 1000000, clk cycles from one temperature-read completion to the next read start.
REQ-002 Parameter TIMEOUT_CYCLES, default 65536, clk cycles allowed between spi_start and detected spi_done.
REQ-003 clk  input  1  single block clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 enable  input  1  level; 1 = run the configure/poll sequence, 0 = return to IDLE after any in-flight transfer.
REQ-006 cfg_data  input  8  sensor configuration byte, sampled at CFG_START.
REQ-007 spi_start  output  1  one-cycle pulse requesting an SPI transaction.
REQ-008 spi_wr_bytes  output  2  command/data bytes to shift out.
REQ-009 spi_rd_bytes  output  2  bytes to shift in.
REQ-010 spi_tx_data  output  16  outgoing bytes, MSB byte first.
REQ-011 spi_rx_data  input  32  incoming bytes from the SPI master.
REQ-012 spi_done  input  1  transaction-complete pulse from the SPI master, asynchronous to clk.
REQ-013 temp_data  output  16  last valid temperature word.
REQ-014 temp_valid  output  1  one-cycle pulse when temp_data updates.
REQ-015 busy  output  1  high in every state except IDLE and ERROR.
REQ-016 error  output  1  sticky timeout flag, high in ERROR.

Function
REQ-017 States: IDLE, CFG_START, CFG_WAIT, POLL_WAIT, RD_START, RD_WAIT, ERROR.
REQ-018 IDLE -> CFG_START when enable=1; otherwise hold IDLE.
REQ-019 CFG_START: assert spi_start for exactly one cycle with spi_wr_bytes=2, spi_rd_bytes=0, spi_tx_data={CMD_WR_CFG, cfg_data}; go to CFG_WAIT next cycle.
REQ-020 CFG_WAIT -> POLL_WAIT on detected done, with the poll counter loaded to 0 so the first read starts after a full POLL_CYCLES wait.
REQ-021 POLL_WAIT: increment the poll counter; on reaching POLL_CYCLES-1 go to RD_START.
REQ-022 RD_START: one-cycle spi_start with spi_wr_bytes=1, spi_rd_bytes=2, spi_tx_data={CMD_RD_TEMP, 8'h00}; go to RD_WAIT.
REQ-023 RD_WAIT: on detected done, capture temp_data <= spi_rx_data[15:0], pulse temp_valid in the same cycle temp_data changes, then go to POLL_WAIT with the counter cleared.
REQ-024 spi_wr_bytes, spi_rd_bytes and spi_tx_data are held stable from the spi_start cycle until done is detected.
REQ-025 spi_done passes through a two-flop synchroniser; a rising edge of the synchronised signal is a detected done. Done latency is 3 clk cycles from the spi_done rise to the state change.
REQ-026 A detected done outside CFG_WAIT and RD_WAIT is ignored.
REQ-027 In CFG_WAIT and RD_WAIT a timeout counter runs from 0; on reaching TIMEOUT_CYCLES-1 without a detected done, go to ERROR.
REQ-028 If done is detected in the same cycle the timeout count expires, done wins.
REQ-029 ERROR holds with error=1 until enable is low; then go to IDLE and clear error.
REQ-030 enable=0 in POLL_WAIT, CFG_START or RD_START: go to IDLE next cycle, with no spi_start issued.
REQ-031 enable=0 in a WAIT state: complete the WAIT state, including capture and timeout, then go to IDLE instead of POLL_WAIT.
REQ-032 Poll and timeout counters are sized by $clog2 of their parameters and never wrap.

Reset
REQ-033 rst_n low asynchronously forces state=IDLE, spi_start=0, spi_wr_bytes=0, spi_rd_bytes=0, spi_tx_data=0, temp_data=0, temp_valid=0, error=0, and clears all counters and synchroniser flops.
REQ-034 Reset during a transfer abandons it; a later spi_done is ignored because the state is IDLE.

Structure
REQ-035 Package temp_sens_pkg holds the state enum plus CMD_WR_CFG=8'h08 and CMD_RD_TEMP=8'h50.
REQ-036 Sub-module sync_rise (two-flop synchroniser plus rising-edge detector, clk/rst_n) produces the detected-done pulse.

Verification
REQ-037 enable=1, cfg_data=8'h80, done returned 20 cycles after each start -> first start with tx=16'h0880, wr=2, rd=0; after POLL_CYCLES a start with tx=16'h5000, wr=1, rd=2.
REQ-038 Read with spi_rx_data=32'h0000_0C80 -> temp_data=16'h0C80 and temp_valid high for exactly 1 cycle, 3 cycles after the spi_done rise.
REQ-039 spi_done never asserted after the read start -> error=1 at TIMEOUT_CYCLES; enable=0 -> IDLE with error=0.
REQ-040 spi_done rising in the exact cycle the timeout expires -> temp_valid pulses and error stays 0.
REQ-041 enable=0 during POLL_WAIT -> IDLE next cycle with no spi_start; enable=0 during RD_WAIT -> capture completes, then IDLE.
REQ-042 rst_n low mid-RD_WAIT, then spi_done pulse -> outputs at reset values and temp_valid stays 0.
